// File: rtl/ppu_scanline_sequencer.sv
// PPU per-frame scanline sequencer: vsync sync, line req/done handshake, pixel gating.
// Optional NMI output enabled by defining PPU_SEQ_NMI_EN.
module ppu_scanline_sequencer #(
   parameter int VISIBLE_LINES = 240,
   parameter int LINE_W        = 8,
   parameter int FRAME_W       = 8,
   parameter int PIX_W         = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               vs_in,
   output logic               line_start,
   output logic [LINE_W-1:0]  y_idx,
   input  logic               line_done,
   input  logic               pix_valid,
   input  logic [PIX_W-1:0]   pix_in,
   output logic               pix_ready,
   input  logic               fifo_full,
   input  logic               fifo_empty,
   output logic               fifo_we,
   output logic               fifo_re,
   output logic [PIX_W-1:0]   fifo_din,
   output logic               in_vblank,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic               odd_frame,
   output logic               overrun,
`ifdef PPU_SEQ_NMI_EN
   input  logic               nmi_en,
   input  logic               nmi_ack,
   output logic               nmi_n,
`endif
   input  logic               clr_overrun
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LS   = 2'd1;
   localparam logic [1:0] S_BUSY = 2'd2;
   localparam logic [1:0] S_VB   = 2'd3;

   localparam logic [LINE_W-1:0] LAST_Y = LINE_W'(VISIBLE_LINES - 1);

   logic [1:0]        state, state_nx;
   logic [LINE_W-1:0] y_nx;
   logic              cnt_inc, ov_set, vb_entry;
   logic              vs_s1, vs_s2, vs_s3;
   logic              frame_start;

   // Third flop only remembers the synced level for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_s1 <= 1'b0;
         vs_s2 <= 1'b0;
         vs_s3 <= 1'b0;
      end else begin
         vs_s1 <= vs_in;
         vs_s2 <= vs_s1;
         vs_s3 <= vs_s2;
      end
   end

   assign frame_start = vs_s2 & ~vs_s3;

   always_comb begin
      state_nx = state;
      y_nx     = y_idx;
      cnt_inc  = 1'b0;
      ov_set   = 1'b0;
      vb_entry = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (frame_start) begin
               state_nx = S_LS;
               y_nx     = '0;
            end
         end
         S_LS: begin
            if (frame_start) begin
               ov_set  = 1'b1;
               cnt_inc = 1'b1;
               y_nx    = '0;
            end else begin
               state_nx = S_BUSY;
            end
         end
         S_BUSY: begin
            // A new frame overrides a line finishing on the same edge.
            if (frame_start) begin
               ov_set   = 1'b1;
               cnt_inc  = 1'b1;
               y_nx     = '0;
               state_nx = S_LS;
            end else if (line_done) begin
               if (y_idx == LAST_Y) begin
                  state_nx = S_VB;
                  y_nx     = '0;
                  vb_entry = 1'b1;
               end else begin
                  state_nx = S_LS;
                  y_nx     = y_idx + LINE_W'(1);
               end
            end
         end
         S_VB: begin
            if (frame_start) begin
               state_nx = S_LS;
               cnt_inc  = 1'b1;
               y_nx     = '0;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         y_idx     <= '0;
         frame_cnt <= '0;
         overrun   <= 1'b0;
      end else begin
         state <= state_nx;
         y_idx <= y_nx;
         if (cnt_inc) frame_cnt <= frame_cnt + FRAME_W'(1);
         if (ov_set) overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

`ifdef PPU_SEQ_NMI_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) nmi_n <= 1'b1;
      else if (vb_entry && nmi_en) nmi_n <= 1'b0;
      else if (nmi_ack || frame_start || !nmi_en) nmi_n <= 1'b1;
   end
`endif

   assign line_start = (state == S_LS);
   assign in_vblank  = (state == S_IDLE) || (state == S_VB);
   assign odd_frame  = frame_cnt[0];

   assign pix_ready = ~fifo_full;
   assign fifo_we   = pix_valid & ~fifo_full;
   assign fifo_din  = pix_in;
   assign fifo_re   = ~fifo_empty;

endmodule

// File: tb/tb_ppu_scanline_sequencer.sv
// Directed bench for ppu_scanline_sequencer (VISIBLE_LINES=4, FRAME_W=2).
// NMI checks compile in when PPU_SEQ_NMI_EN is defined.
module tb_ppu_scanline_sequencer;

   logic       clk = 1'b0;
   logic       reset_n, vs_in, line_done, pix_valid;
   logic [5:0] pix_in, fifo_din;
   logic       fifo_full, fifo_empty, clr_overrun;
   logic       line_start, pix_ready, fifo_we, fifo_re;
   logic       in_vblank, odd_frame, overrun;
   logic [7:0] y_idx;
   logic [1:0] frame_cnt;
`ifdef PPU_SEQ_NMI_EN
   logic       nmi_en, nmi_ack, nmi_n;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ppu_scanline_sequencer #(
      .VISIBLE_LINES(4), .LINE_W(8), .FRAME_W(2), .PIX_W(6)
   ) dut (
      .clk(clk), .reset_n(reset_n), .vs_in(vs_in),
      .line_start(line_start), .y_idx(y_idx), .line_done(line_done),
      .pix_valid(pix_valid), .pix_in(pix_in), .pix_ready(pix_ready),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_din(fifo_din),
      .in_vblank(in_vblank), .frame_cnt(frame_cnt),
      .odd_frame(odd_frame), .overrun(overrun),
`ifdef PPU_SEQ_NMI_EN
      .nmi_en(nmi_en), .nmi_ack(nmi_ack), .nmi_n(nmi_n),
`endif
      .clr_overrun(clr_overrun)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nmi_chk(input string tag, input logic exp);
`ifdef PPU_SEQ_NMI_EN
      chk(tag, nmi_n, exp);
`endif
   endtask

   // From LINE_BUSY: finish the line, expect the next line_start, go busy.
   task automatic done_line(input int ey);
      line_done = 1'b1;
      step();
      line_done = 1'b0;
      chk("y_next", y_idx, ey);
      chk("ls_next", line_start, 1);
      step();
   endtask

   task automatic last_line();
      line_done = 1'b1;
      step();
      line_done = 1'b0;
      chk("vb_enter", in_vblank, 1);
      chk("vb_y0", y_idx, 0);
      chk("vb_ls0", line_start, 0);
   endtask

   // frame_start lands on the third edge after vs_in rises.
   task automatic vsync();
      vs_in = 1'b1;
      repeat (3) step();
      vs_in = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; vs_in = 1'b0; line_done = 1'b0;
      pix_valid = 1'b0; pix_in = '0; fifo_full = 1'b1;
      fifo_empty = 1'b1; clr_overrun = 1'b0;
`ifdef PPU_SEQ_NMI_EN
      nmi_en = 1'b1; nmi_ack = 1'b0;
`endif
      repeat (2) step();
      chk("rst_ls", line_start, 0);
      chk("rst_y", y_idx, 0);
      chk("rst_vb", in_vblank, 1);
      chk("rst_cnt", frame_cnt, 0);
      chk("rst_ov", overrun, 0);
      chk("rst_we", fifo_we, 0);
      chk("rst_re", fifo_re, 0);
      nmi_chk("rst_nmi", 1);
      reset_n = 1'b1;
      step();

      // Frame 1: sync latency then four lines.
      vs_in = 1'b1;
      step();
      chk("sync1", line_start, 0);
      step();
      chk("sync2", line_start, 0);
      step();
      vs_in = 1'b0;
      chk("sync3_ls", line_start, 1);
      chk("sync3_y", y_idx, 0);
      chk("idle_nocnt", frame_cnt, 0);
      step();
      chk("busy_ls0", line_start, 0);
      done_line(1);
      done_line(2);
      done_line(3);
      last_line();
      nmi_chk("nmi_set", 0);
`ifdef PPU_SEQ_NMI_EN
      nmi_ack = 1'b1;
      step();
      nmi_ack = 1'b0;
      chk("nmi_ack", nmi_n, 1);
`endif
      line_done = 1'b1;
      step();
      line_done = 1'b0;
      chk("vb_ignore_done", in_vblank, 1);
      chk("vb_ignore_ls", line_start, 0);

      // Frame 2: overrun from LINE_BUSY at y=2.
      vsync();
      chk("f2_cnt", frame_cnt, 1);
      chk("f2_odd", odd_frame, 1);
      chk("f2_ls", line_start, 1);
      chk("f2_ov0", overrun, 0);
      step();
      done_line(1);
      done_line(2);
      vsync();
      chk("ovr_set", overrun, 1);
      chk("ovr_ls", line_start, 1);
      chk("ovr_y", y_idx, 0);
      chk("ovr_cnt", frame_cnt, 2);
      chk("ovr_odd", odd_frame, 0);
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      chk("ovr_clr", overrun, 0);

      // frame_start, line_done at y=3 and clr_overrun on one edge.
      done_line(1);
      done_line(2);
      done_line(3);
      vs_in = 1'b1;
      step();
      step();
      line_done = 1'b1;
      clr_overrun = 1'b1;
      step();
      line_done = 1'b0;
      clr_overrun = 1'b0;
      vs_in = 1'b0;
      chk("same_ov", overrun, 1);
      chk("same_novb", in_vblank, 0);
      chk("same_ls", line_start, 1);
      chk("same_y", y_idx, 0);
      chk("same_cnt", frame_cnt, 3);
      chk("same_odd", odd_frame, 1);
      step();
      done_line(1);
      done_line(2);
      done_line(3);
      last_line();
      nmi_chk("nmi_set2", 0);
`ifdef PPU_SEQ_NMI_EN
      nmi_en = 1'b0;
      step();
      chk("nmi_en_off", nmi_n, 1);
      nmi_en = 1'b1;
`endif

      // Wrap 3 -> 0.
      vsync();
      chk("wrap_cnt", frame_cnt, 0);
      chk("wrap_odd", odd_frame, 0);
      step();
      done_line(1);
      done_line(2);
      done_line(3);
      last_line();
      nmi_chk("nmi_set3", 0);
      vsync();
      nmi_chk("nmi_fs_rel", 1);
      chk("f5_cnt", frame_cnt, 1);

      // Pixel path is purely combinational.
      pix_valid = 1'b1;
      pix_in = 6'h2a;
      fifo_full = 1'b1;
      #1;
      chk("pix_ready_full", pix_ready, 0);
      chk("we_full", fifo_we, 0);
      fifo_full = 1'b0;
      #1;
      chk("pix_ready", pix_ready, 1);
      chk("we", fifo_we, 1);
      chk("din", fifo_din, 6'h2a);
      fifo_empty = 1'b0;
      #1;
      chk("re", fifo_re, 1);
      pix_valid = 1'b0;
      #1;
      chk("we_novalid", fifo_we, 0);

      // Reset mid-line at y=2 with overrun still set.
      step();
      done_line(1);
      done_line(2);
      fifo_full = 1'b1;
      fifo_empty = 1'b1;
      pix_in = '0;
      reset_n = 1'b0;
      #1;
      chk("mr_ls", line_start, 0);
      chk("mr_y", y_idx, 0);
      chk("mr_vb", in_vblank, 1);
      chk("mr_cnt", frame_cnt, 0);
      chk("mr_ov", overrun, 0);
      chk("mr_din", fifo_din, 0);
      nmi_chk("mr_nmi", 1);
      step();
      reset_n = 1'b1;
      step();
      line_done = 1'b1;
      step();
      line_done = 1'b0;
      step();
      chk("mr_done_ls", line_start, 0);
      chk("mr_done_vb", in_vblank, 1);
      chk("mr_done_y", y_idx, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
